// File: rtl/bcd_match_counter_disp_pkg.sv
// Shared constants for the multi-decade BCD match counter and its 7-segment scan path.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the output register.
package bcd_match_counter_disp_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_match_counter_disp_if.sv
// Control, data and display bundle of the BCD match counter.
// No valid/ready pair: EN qualifies every CP edge, LD is a one-edge command, outputs are always valid.
interface bcd_match_counter_disp_if #(
  parameter int DIGITS = 2
);
  import bcd_match_counter_disp_pkg::*;

  logic                      EN;
  logic                      LD;
  logic                      MODE;
  logic [DIGIT_W*DIGITS-1:0] Dn;
  logic [DIGIT_W*DIGITS-1:0] DataB;
  logic [DIGIT_W*DIGITS-1:0] Q;
  logic                      TC;
  logic                      HALT;
  logic [6:0]                Seg;
  logic [DIGITS-1:0]         Dig;

  modport master (
    output EN, LD, MODE, Dn, DataB,
    input  Q, TC, HALT, Seg, Dig
  );

  modport slave (
    input  EN, LD, MODE, Dn, DataB,
    output Q, TC, HALT, Seg, Dig
  );

endinterface

// File: rtl/bcd_match_counter_disp_seg7_bcd_decode.sv
// Combinational nibble to 7-segment pattern; non-BCD codes blank the digit.
module seg7_bcd_decode
  import bcd_match_counter_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [6:0]         seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_match_counter_disp.sv
// Cascaded BCD counter with load, terminal-value match (reload or halt) and a
// time-multiplexed single 7-segment display driver.
module bcd_match_counter_disp
  import bcd_match_counter_disp_pkg::*;
#(
  parameter int DIGITS     = 2,
  parameter int SCAN_DIV   = 4,
  parameter bit SEG_ACT_HI = 1
) (
  input logic                     CP,
  input logic                     MRN,
  bcd_match_counter_disp_if.slave bus
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic POL_INV = !SEG_ACT_HI;

  logic [W-1:0]         q;
  logic [W-1:0]         q_inc;
  logic                 tc;
  logic                 halt;
  logic                 match;
  logic [DIGITS-1:0]    carry;
  logic [DIGIT_W-1:0]   q_dig [DIGITS];

  logic [SCAN_DIV-1:0]  scan_cnt;
  logic [IDX_W-1:0]     idx;
  logic [6:0]           seg_raw;
  logic [6:0]           seg_r;
  logic [DIGITS-1:0]    dig_r;

  assign carry[0] = 1'b1;

  // Any nibble >= 9 (including loaded A..F) rolls to 0 and carries onward.
  for (genvar i = 0; i < DIGITS; i++) begin : g_decade
    assign q_dig[i] = q[i*DIGIT_W +: DIGIT_W];
    assign q_inc[i*DIGIT_W +: DIGIT_W] =
      !carry[i]               ? q_dig[i] :
      (q_dig[i] >= BCD_MAX)   ? '0       :
                                q_dig[i] + 4'd1;
    if (i < DIGITS - 1) begin : g_carry
      assign carry[i+1] = carry[i] & (q_dig[i] >= BCD_MAX);
    end
  end

  // A halted counter never re-matches, so TC cannot repeat while HALT is set.
  assign match = bus.EN & ~halt & (q == bus.DataB);

  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN) begin
      q    <= '0;
      tc   <= 1'b0;
      halt <= 1'b0;
    end else if (bus.LD) begin
      q    <= bus.Dn;
      tc   <= 1'b0;
      halt <= 1'b0;
    end else if (match) begin
      tc <= 1'b1;
      if (bus.MODE) halt <= 1'b1;
      else          q    <= bus.Dn;
    end else begin
      tc <= 1'b0;
      if (bus.EN && !halt) q <= q_inc;
    end
  end

  seg7_bcd_decode u_decode (
    .bcd (q_dig[idx]),
    .seg (seg_raw)
  );

  // Scan runs regardless of EN/HALT; Seg and Dig share one register stage so they never skew.
  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg_r    <= SEG_0 ^ {7{POL_INV}};
      dig_r    <= DIGITS'(1) ^ {DIGITS{POL_INV}};
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (scan_cnt == '1) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      seg_r <= seg_raw ^ {7{POL_INV}};
      dig_r <= (DIGITS'(1) << idx) ^ {DIGITS{POL_INV}};
    end
  end

  assign bus.Q    = q;
  assign bus.TC   = tc;
  assign bus.HALT = halt;
  assign bus.Seg  = seg_r;
  assign bus.Dig  = dig_r;

endmodule

// File: tb/tb_bcd_match_counter_disp.sv
// Scoreboard bench for bcd_match_counter_disp (DIGITS=2, SCAN_DIV=2, active-high display).
module tb_bcd_match_counter_disp;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int EW     = W + 2 + 7 + DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_match_counter_disp_if #(.DIGITS(DIGITS)) bus ();

  bcd_match_counter_disp #(
    .DIGITS     (DIGITS),
    .SCAN_DIV   (2),
    .SEG_ACT_HI (1)
  ) dut (
    .CP  (clk),
    .MRN (rst_n),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state
  logic [W-1:0] m_q;
  logic         m_halt;
  logic [1:0]   m_cnt;
  logic         m_idx;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   nib;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      nib = v[i*4 +: 4];
      if (nib < 4'd9) begin
        r[i*4 +: 4] = nib + 4'd1;
        return r;
      end
      r[i*4 +: 4] = 4'd0;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_q    = '0;
    m_halt = 1'b0;
    m_cnt  = '0;
    m_idx  = 1'b0;
  endtask

  // Drive one edge's inputs at a negedge, predict, then compare after the edge.
  task automatic step(input logic ld, input logic en, input logic mode,
                      input logic [W-1:0] dn, input logic [W-1:0] datab);
    logic [W-1:0]        nq;
    logic                ntc;
    logic                nhalt;
    logic [6:0]          eseg;
    logic [DIGITS-1:0]   edig;
    logic [EW-1:0]       got;
    int                  sh;
    bus.LD = ld; bus.EN = en; bus.MODE = mode; bus.Dn = dn; bus.DataB = datab;
    sh   = m_idx ? 4 : 0;
    eseg = seg_tab[m_q[sh +: 4]];
    edig = m_idx ? 2'b10 : 2'b01;
    nq = m_q; ntc = 1'b0; nhalt = m_halt;
    if (ld) begin
      nq = dn; nhalt = 1'b0;
    end else if (en && !m_halt && m_q == datab) begin
      ntc = 1'b1;
      if (mode) nhalt = 1'b1;
      else      nq = dn;
    end else if (en && !m_halt) begin
      nq = bcd_inc(m_q);
    end
    if (m_cnt == 2'd3) m_idx = ~m_idx;
    m_cnt  = m_cnt + 2'd1;
    m_q    = nq;
    m_halt = nhalt;
    exp_q.push_back({nq, ntc, nhalt, eseg, edig});
    @(posedge clk);
    @(negedge clk);
    got = exp_q.pop_front();
    check("q",    32'(bus.Q),    32'(got[EW-1 -: W]));
    check("tc",   32'(bus.TC),   32'(got[EW-W-1]));
    check("halt", 32'(bus.HALT), 32'(got[EW-W-2]));
    check("seg",  32'(bus.Seg),  32'(got[DIGITS +: 7]));
    check("dig",  32'(bus.Dig),  32'(got[DIGITS-1:0]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q"},    32'(bus.Q),    32'h00);
    check({tag, "_tc"},   32'(bus.TC),   32'h0);
    check({tag, "_halt"}, 32'(bus.HALT), 32'h0);
    check({tag, "_seg"},  32'(bus.Seg),  32'h3F);
    check({tag, "_dig"},  32'(bus.Dig),  32'h01);
  endtask

  // Asserts MRN between edges and checks outputs before any clock edge arrives.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] rnd_dn;
  logic [W-1:0] rnd_db;

  initial begin
    bus.EN = 1'b0; bus.LD = 1'b0; bus.MODE = 1'b0; bus.Dn = '0; bus.DataB = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Reset mid-count at 37
    step(1, 0, 0, 8'h35, 8'h99);
    step(0, 1, 0, 8'h00, 8'h99);
    step(0, 1, 0, 8'h00, 8'h99);
    check("pre_rst_q", 32'(bus.Q), 32'h37);
    async_reset();

    // Decade carry
    step(1, 0, 0, 8'h08, 8'h99);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 8'h99);

    // Reload on match
    step(1, 0, 0, 8'h10, 8'h12);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h05, 8'h12);

    // Halt on match, then LD releases
    step(1, 0, 1, 8'h00, 8'h03);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 8'h00, 8'h03);
    step(1, 1, 1, 8'h00, 8'h03);
    step(0, 1, 0, 8'h00, 8'h99);
    step(0, 1, 0, 8'h00, 8'h99);

    // All-9s wrap and LD/match collision
    step(1, 0, 0, 8'h99, 8'h42);
    step(0, 1, 0, 8'h11, 8'h42);
    step(1, 0, 0, 8'h42, 8'h42);
    step(1, 1, 0, 8'h77, 8'h42);

    // Non-BCD nibble rolls to 0 with carry
    step(1, 0, 0, 8'h3C, 8'h99);
    step(0, 1, 0, 8'h00, 8'h99);

    // Scan with Q held at 4A
    step(1, 0, 0, 8'h4A, 8'h00);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 8'h00, 8'h4A);

    // Reset during halt
    step(1, 0, 1, 8'h01, 8'h02);
    step(0, 1, 1, 8'h00, 8'h02);
    step(0, 1, 1, 8'h00, 8'h02);
    async_reset();

    // Randomised traffic, biased towards matches
    for (int i = 0; i < 60; i++) begin
      rnd_dn = W'($urandom_range(0, 255));
      rnd_db = ($urandom_range(0, 1) == 1) ? bcd_inc(m_q) : W'($urandom_range(0, 255));
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), rnd_dn, rnd_db);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
